inta_sequencer: RTL and testbench

- Clocked controller that sequences the 8086-mode interrupt-acknowledge handshake for the PIC.
- Synchronises the external INTA strobe and drives INT.
- On the first INTA pulse: freezes the priority datapath, latches the ISR and clears the IRR bit.
- On the second INTA pulse: drives the vector (or defers it to a slave), then issues an AEOI clear when enabled.
- Replaces the edge-triggered acknowledge logic in the control block with one synchronous FSM.

---
 rtl/inta_sequencer_if.sv | 36 +++
 rtl/inta_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_inta_sequencer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/inta_sequencer_if.sv
// Acknowledge-handshake bundle between the CPU-facing pins, the PIC control blocks and the inta_sequencer.
// The sequencer attaches through the slave modport and the driving side through the master modport.
`timescale 1ns/1ps
interface inta_sequencer_if;
    logic       INTA;
    logic       init_pulse;
    logic       int_request;
    logic [7:0] interrupt_id;
    logic [7:0] icw2_base;
    logic       sngl;
    logic       sp_en;
    logic       slave_on_ir;
    logic       aeoi;
    logic       INT;
    logic       freeze;
    logic [7:0] latch_in_service;
    logic [7:0] clear_interrupt_request;
    logic [7:0] vector_out;
    logic       vector_oe;
    logic [7:0] end_of_interrupt;
    logic       ack_done;

    modport slave (
        input  INTA, init_pulse, int_request, interrupt_id, icw2_base,
               sngl, sp_en, slave_on_ir, aeoi,
        output INT, freeze, latch_in_service, clear_interrupt_request,
               vector_out, vector_oe, end_of_interrupt, ack_done
    );

    modport master (
        output INTA, init_pulse, int_request, interrupt_id, icw2_base,
               sngl, sp_en, slave_on_ir, aeoi,
        input  INT, freeze, latch_in_service, clear_interrupt_request,
               vector_out, vector_oe, end_of_interrupt, ack_done
    );
endinterface

// File: rtl/inta_sequencer.sv
// 8086-mode interrupt-acknowledge sequencer: synchronises INTA and runs IDLE/PENDING/ACK1/GAP/ACK2.
// Optional macro INTA_TIMEOUT_EN abandons a sequence after TIMEOUT_CYCLES without the next INTA edge.
`timescale 1ns/1ps
module inta_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    inta_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PENDING = 3'd1,
        S_ACK1    = 3'd2,
        S_GAP     = 3'd3,
        S_ACK2    = 3'd4
    } state_t;

    if ((SYNC_STAGES < 2) || (TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 256)) begin : g_param_check
        $error("inta_sequencer: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES in 1..256");
    end

    // Lowest set bit wins; an empty id gives the spurious index 7.
    function automatic logic [2:0] low_index(input logic [7:0] id);
        low_index = 3'b111;
        for (int i = 7; i >= 0; i--) begin
            low_index = id[i] ? 3'(i) : low_index;
        end
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   inta_prev_r;
    logic                   inta_fall_s;
    logic                   inta_rise_s;
    state_t                 state_r;
    state_t                 next_state_s;
    logic [7:0]             id_lat_r;
    logic [7:0]             id_lat_s;
    logic                   oe_en_s;
    logic                   take_ack1_s;
    logic                   finish_s;

    logic       int_s,  int_r;
    logic       freeze_s, freeze_r;
    logic [7:0] latch_s, latch_r;
    logic [7:0] clear_s, clear_r;
    logic [7:0] vector_s, vector_r;
    logic       vector_oe_s, vector_oe_r;
    logic [7:0] eoi_s, eoi_r;
    logic       ack_done_s, ack_done_r;

    // INTA synchroniser chain plus edge-detect history flop; idle level is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r      <= '1;
            inta_prev_r <= 1'b1;
        end else begin
            sync_r      <= {sync_r[SYNC_STAGES-2:0], bus.INTA};
            inta_prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign inta_fall_s = inta_prev_r & ~sync_r[SYNC_STAGES-1];
    assign inta_rise_s = ~inta_prev_r & sync_r[SYNC_STAGES-1];

`ifdef INTA_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_cnt_r;
    logic       timeout_s;

    assign timeout_s = (tmo_cnt_r == TMO_LAST);

    // Wait counter for the two INTA gaps; restarts on every state change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_r <= 8'd0;
        end else if ((next_state_s != state_r) ||
                     ((state_r != S_ACK1) && (state_r != S_GAP))) begin
            tmo_cnt_r <= 8'd0;
        end else begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
        end
    end
`else
    logic timeout_s;
    assign timeout_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; an ICW1 write overrides any INTA edge.
    always_comb begin
        next_state_s = state_r;
        if (bus.init_pulse) begin
            next_state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.int_request) next_state_s = S_PENDING;
                    else                 next_state_s = S_IDLE;
                end
                S_PENDING: begin
                    if (inta_fall_s) next_state_s = S_ACK1;
                    else             next_state_s = S_PENDING;
                end
                S_ACK1: begin
                    if (inta_rise_s)    next_state_s = S_GAP;
                    else if (timeout_s) next_state_s = S_IDLE;
                    else                next_state_s = S_ACK1;
                end
                S_GAP: begin
                    if (inta_fall_s)    next_state_s = S_ACK2;
                    else if (timeout_s) next_state_s = S_IDLE;
                    else                next_state_s = S_GAP;
                end
                S_ACK2: begin
                    if (inta_rise_s) next_state_s = S_IDLE;
                    else             next_state_s = S_ACK2;
                end
                default: next_state_s = S_IDLE;
            endcase
        end
    end

    // Output logic: values the output registers take on the coming edge.
    always_comb begin
        take_ack1_s = (state_r == S_PENDING) && (next_state_s == S_ACK1);
        finish_s    = (state_r == S_ACK2) && (next_state_s == S_IDLE) && !bus.init_pulse;
        // A slave's cascade match arrives already folded into slave_on_ir.
        oe_en_s     = bus.sngl || (bus.sp_en && !bus.slave_on_ir) ||
                      (!bus.sp_en && bus.slave_on_ir);

        if (bus.init_pulse) id_lat_s = 8'h00;
        else if (take_ack1_s) id_lat_s = bus.interrupt_id;
        else id_lat_s = id_lat_r;

        int_s       = (next_state_s != S_IDLE);
        freeze_s    = (next_state_s == S_ACK1) || (next_state_s == S_GAP) ||
                      (next_state_s == S_ACK2);
        latch_s     = take_ack1_s ? bus.interrupt_id : 8'h00;
        clear_s     = take_ack1_s ? bus.interrupt_id : 8'h00;
        vector_oe_s = (next_state_s == S_ACK2) && oe_en_s;
        ack_done_s  = finish_s;
        if ((next_state_s == S_GAP) || (next_state_s == S_ACK2)) begin
            vector_s = {bus.icw2_base[7:3], low_index(id_lat_r)};
        end else begin
            vector_s = 8'h00;
        end
        if (finish_s && bus.aeoi && (id_lat_r != 8'h00)) begin
            eoi_s = id_lat_r;
        end else begin
            eoi_s = 8'h00;
        end
    end

    // Output and latched-id registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_lat_r    <= 8'h00;
            int_r       <= 1'b0;
            freeze_r    <= 1'b0;
            latch_r     <= 8'h00;
            clear_r     <= 8'h00;
            vector_r    <= 8'h00;
            vector_oe_r <= 1'b0;
            eoi_r       <= 8'h00;
            ack_done_r  <= 1'b0;
        end else begin
            id_lat_r    <= id_lat_s;
            int_r       <= int_s;
            freeze_r    <= freeze_s;
            latch_r     <= latch_s;
            clear_r     <= clear_s;
            vector_r    <= vector_s;
            vector_oe_r <= vector_oe_s;
            eoi_r       <= eoi_s;
            ack_done_r  <= ack_done_s;
        end
    end

    assign bus.INT                     = int_r;
    assign bus.freeze                  = freeze_r;
    assign bus.latch_in_service        = latch_r;
    assign bus.clear_interrupt_request = clear_r;
    assign bus.vector_out              = vector_r;
    assign bus.vector_oe               = vector_oe_r;
    assign bus.end_of_interrupt        = eoi_r;
    assign bus.ack_done                = ack_done_r;

endmodule

// File: tb/tb_inta_sequencer.sv
// Scoreboard bench for inta_sequencer: expected pulses and completion records are queued as each
// acknowledge is driven and consumed by a negedge monitor when the sequencer produces them.
`timescale 1ns/1ps
module tb_inta_sequencer;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    inta_sequencer_if bus();

    inta_sequencer #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [7:0] vec;
        logic       oe;
        logic [7:0] eoi;
    } rec_t;

    int         n_cmp = 0;
    int         n_err = 0;
    rec_t       q_rec[$];
    logic [7:0] q_latch[$];
    logic [7:0] cap_vec = 8'h00;
    logic       seen_oe = 1'b0;
    logic [7:0] eoi_or  = 8'h00;
    int         eoi_cnt = 0;
    rec_t       mon_rec;
    logic [7:0] mon_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_vector(input logic [7:0] base, input logic [7:0] id);
        logic [2:0] idx;
        idx = 3'd7;
        for (int i = 0; i < 8; i++) begin
            if (id[i]) begin
                idx = 3'(i);
                break;
            end
        end
        return {base[7:3], idx};
    endfunction

    // Monitor: consume queued expectations as the DUT produces pulses and completions.
    always @(negedge clk) begin
        if (reset_n) begin
            if ((bus.latch_in_service != 8'h00) || (bus.clear_interrupt_request != 8'h00)) begin
                if (q_latch.size() == 0) begin
                    check("latch_unexpected", {bus.latch_in_service, bus.clear_interrupt_request}, 16'h0000);
                end else begin
                    mon_exp = q_latch.pop_front();
                    check("latch_in_service", bus.latch_in_service, mon_exp);
                    check("clear_irr", bus.clear_interrupt_request, mon_exp);
                end
            end
            if (bus.end_of_interrupt != 8'h00) begin
                eoi_or = eoi_or | bus.end_of_interrupt;
                eoi_cnt++;
            end
            if (bus.vector_oe) seen_oe = 1'b1;
            if (bus.freeze) cap_vec = bus.vector_out;
            if (bus.ack_done) begin
                if (q_rec.size() == 0) begin
                    check("ack_unexpected", bus.ack_done, 1'b0);
                end else begin
                    mon_rec = q_rec.pop_front();
                    check("vector_out", cap_vec, mon_rec.vec);
                    check("vector_oe_seen", seen_oe, mon_rec.oe);
                    check("eoi_value", eoi_or, mon_rec.eoi);
                    check("eoi_cycles", eoi_cnt, (mon_rec.eoi != 8'h00) ? 1 : 0);
                    check("int_at_done", bus.INT, 1'b0);
                end
                seen_oe = 1'b0;
                eoi_or  = 8'h00;
                eoi_cnt = 0;
            end
        end
    end

    task automatic inta_pulse();
        #3 bus.INTA = 1'b0;
        repeat (4) @(posedge clk);
        #3 bus.INTA = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic [7:0] id, input logic [7:0] base, input logic s,
                             input logic sp, input logic slv, input logic ae);
        bus.interrupt_id = id;
        bus.icw2_base    = base;
        bus.sngl         = s;
        bus.sp_en        = sp;
        bus.slave_on_ir  = slv;
        bus.aeoi         = ae;
        bus.int_request  = 1'b1;
        @(posedge clk);
        #1;
        check("int_raise", bus.INT, 1'b1);
        bus.int_request = 1'b0;
        if (id != 8'h00) q_latch.push_back(id);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((q_rec.size() != 0) && (k < 20)) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(tag, q_rec.size(), 0);
        check("int_after", bus.INT, 1'b0);
        check("freeze_after", bus.freeze, 1'b0);
    endtask

    task automatic full_seq(input logic [7:0] id, input logic [7:0] base, input logic s,
                            input logic sp, input logic slv, input logic ae, input logic oe);
        rec_t r;
        start_req(id, base, s, sp, slv, ae);
        r.vec = exp_vector(base, id);
        r.oe  = oe;
        r.eoi = (ae && (id != 8'h00)) ? id : 8'h00;
        q_rec.push_back(r);
        inta_pulse();
        check("freeze_ack1", bus.freeze, 1'b1);
        check("int_hold", bus.INT, 1'b1);
        inta_pulse();
        drain("seq_done");
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rec_t r;
        bus.INTA = 1'b1; bus.init_pulse = 1'b0; bus.int_request = 1'b0;
        bus.interrupt_id = 8'h00; bus.icw2_base = 8'h00; bus.sngl = 1'b1;
        bus.sp_en = 1'b1; bus.slave_on_ir = 1'b0; bus.aeoi = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_int", bus.INT, 1'b0);
        check("rst_freeze", bus.freeze, 1'b0);
        check("rst_vector", {bus.vector_oe, bus.vector_out}, 9'h000);
        check("rst_pulses", {bus.latch_in_service, bus.end_of_interrupt, bus.ack_done}, 17'h0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // INTA with nothing pending is ignored
        inta_pulse();
        check("idle_inta_int", bus.INT, 1'b0);

        full_seq(8'h08, 8'h40, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);   // single mode, vec 43
        full_seq(8'h08, 8'h40, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);   // AEOI
        full_seq(8'h00, 8'h20, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);   // spurious, vec 27
        full_seq(8'h02, 8'h48, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);   // master with slave on IR
        full_seq(8'h80, 8'h48, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);   // master, own IR
        full_seq(8'h04, 8'hF8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);   // slave, cascade matched
        full_seq(8'h01, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);   // slave, not addressed
        full_seq(8'h14, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);   // multi-bit id

        // init_pulse while in GAP aborts; a later INTA does nothing
        start_req(8'h01, 8'h08, 1'b1, 1'b1, 1'b0, 1'b1);
        inta_pulse();
        check("gap_freeze", bus.freeze, 1'b1);
        bus.init_pulse = 1'b1;
        @(posedge clk);
        #1;
        bus.init_pulse = 1'b0;
        check("init_int", bus.INT, 1'b0);
        check("init_freeze", bus.freeze, 1'b0);
        check("init_vector", bus.vector_out, 8'h00);
        inta_pulse();
        inta_pulse();
        check("post_init_int", bus.INT, 1'b0);

        // asynchronous reset mid-sequence
        start_req(8'h20, 8'h08, 1'b1, 1'b1, 1'b0, 1'b0);
        inta_pulse();
        #2 reset_n = 1'b0;
        #1;
        check("areset_freeze", bus.freeze, 1'b0);
        check("areset_int", bus.INT, 1'b0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

`ifdef INTA_TIMEOUT_EN
        start_req(8'h08, 8'h40, 1'b1, 1'b1, 1'b0, 1'b1);
        inta_pulse();
        check("tmo_freeze_before", bus.freeze, 1'b1);
        repeat (TMO) @(posedge clk);
        #1;
        check("tmo_freeze", bus.freeze, 1'b0);
        check("tmo_int", bus.INT, 1'b0);
`else
        start_req(8'h08, 8'h40, 1'b1, 1'b1, 1'b0, 1'b1);
        r.vec = 8'h43;
        r.oe  = 1'b1;
        r.eoi = 8'h08;
        q_rec.push_back(r);
        inta_pulse();
        repeat (300) @(posedge clk);
        #1;
        check("wait_freeze", bus.freeze, 1'b1);
        inta_pulse();
        drain("long_gap_done");
`endif

        repeat (4) @(posedge clk);
        #1;
        check("latch_queue_left", q_latch.size(), 0);
        check("stray_eoi", eoi_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
